// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port data memory.
// Each accepted request runs IDLE -> ACCESS -> RESP (3 cycles), so at most
// one transaction is ever in flight and responses come back in order.
//
// Parameters:
//   DATA_WIDTH  data word width (bits)
//   ADDR_WIDTH  byte address width; word index is addr[ADDR_WIDTH-1:3]
// Ports:
//   i_clk, i_arst            clock, async active-high reset
//   i_reqN_valid/we/addr/wdata  request from requester N (N = 0,1)
//   o_reqN_ready             request accepted this cycle (IDLE only)
//   o_rspN_valid/rdata/err   one-cycle completion pulse, load data, misaligned
//   o_mem_we/addr/wdata      single-port memory write/address/data
//   i_mem_rdata              memory read data, combinational from o_mem_addr
// Configuration:
//   DMEM_ARB_RR_EN           defined: round-robin on ties
//                            undefined: port 0 has fixed priority
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_arst,

    input  logic                  i_req0_valid,
    input  logic                  i_req0_we,
    input  logic [ADDR_WIDTH-1:0] i_req0_addr,
    input  logic [DATA_WIDTH-1:0] i_req0_wdata,
    output logic                  o_req0_ready,
    output logic                  o_rsp0_valid,
    output logic [DATA_WIDTH-1:0] o_rsp0_rdata,
    output logic                  o_rsp0_err,

    input  logic                  i_req1_valid,
    input  logic                  i_req1_we,
    input  logic [ADDR_WIDTH-1:0] i_req1_addr,
    input  logic [DATA_WIDTH-1:0] i_req1_wdata,
    output logic                  o_req1_ready,
    output logic                  o_rsp1_valid,
    output logic [DATA_WIDTH-1:0] o_rsp1_rdata,
    output logic                  o_rsp1_err,

    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_port;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_mem_we;
    logic                  r_rsp0_valid;
    logic                  r_rsp1_valid;

    logic                  w_idle;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_accept;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_misal;

    assign w_idle = (r_state == IDLE);

`ifdef DMEM_ARB_RR_EN
    // r_last = 1 means port 1 was granted most recently; a tie goes
    // to the other port.
    logic r_last;

    assign w_grant0 = w_idle & i_req0_valid & (~i_req1_valid | r_last);
    assign w_grant1 = w_idle & i_req1_valid & (~i_req0_valid | ~r_last);
`else
    assign w_grant0 = w_idle & i_req0_valid;
    assign w_grant1 = w_idle & i_req1_valid & ~i_req0_valid;
`endif

    assign w_accept    = w_grant0 | w_grant1;
    assign w_sel_we    = w_grant1 ? i_req1_we    : i_req0_we;
    assign w_sel_addr  = w_grant1 ? i_req1_addr  : i_req0_addr;
    assign w_sel_wdata = w_grant1 ? i_req1_wdata : i_req0_wdata;
    assign w_misal     = (r_addr[2:0] != 3'b000);

    assign o_req0_ready = w_grant0;
    assign o_req1_ready = w_grant1;

    // Write enable is registered on accept so it is high for exactly the
    // ACCESS cycle and drops the instant reset is asserted.
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

    // Both ports share one response register; only one valid ever pulses.
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp0_rdata = r_rdata;
    assign o_rsp0_err   = r_err;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp1_rdata = r_rdata;
    assign o_rsp1_err   = r_err;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state      <= IDLE;
            r_port       <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_mem_we     <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            r_last       <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_port   <= w_grant1;
                        r_we     <= w_sel_we;
                        r_addr   <= w_sel_addr;
                        r_wdata  <= w_sel_wdata;
                        r_mem_we <= w_sel_we & (w_sel_addr[2:0] == 3'b000);
                        r_state  <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        r_last   <= w_grant1;
`endif
                    end
                end
                ACCESS: begin
                    r_mem_we     <= 1'b0;
                    r_rdata      <= (!r_we && !w_misal) ? i_mem_rdata : '0;
                    r_err        <= w_misal;
                    r_rsp0_valid <= ~r_port;
                    r_rsp1_valid <= r_port;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_mem_we     <= 1'b0;
                    r_rsp0_valid <= 1'b0;
                    r_rsp1_valid <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: scoreboard of expected responses,
// grant/latency model and a behavioural memory.
module tb_dmem_arbiter;

    localparam int DW = 64;
    localparam int AW = 11;

    typedef struct {
        int          port;
        logic [63:0] rdata;
        logic        err;
        logic        we;
        int          idx;
        logic [63:0] wdata;
        int          acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_arst;
    logic          r0_valid, r0_we, r1_valid, r1_we;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          q0_ready, q1_ready;
    logic          s0_valid, s0_err, s1_valid, s1_err;
    logic [DW-1:0] s0_rdata, s1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    logic [DW-1:0] mem [256] = '{default: '0};

    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (mem_we) mem[mem_addr[10:3]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[10:3]];

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_arst(i_arst),
        .i_req0_valid(r0_valid), .i_req0_we(r0_we),
        .i_req0_addr(r0_addr), .i_req0_wdata(r0_wdata),
        .o_req0_ready(q0_ready), .o_rsp0_valid(s0_valid),
        .o_rsp0_rdata(s0_rdata), .o_rsp0_err(s0_err),
        .i_req1_valid(r1_valid), .i_req1_we(r1_we),
        .i_req1_addr(r1_addr), .i_req1_wdata(r1_wdata),
        .o_req1_ready(q1_ready), .o_rsp1_valid(s1_valid),
        .o_rsp1_rdata(s1_rdata), .o_rsp1_err(s1_err),
        .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_acc = 0;
    int          last_acc = -100;
    int          exp_we_at = -1;
    logic        b_last = 1'b1;
    logic [10:0] exp_we_addr = '0;
    logic [63:0] exp_we_data = '0;
    logic [63:0] shadow [256];
    exp_t        sb [$];
    int          grants [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic mon_step();
        int          c;
        int          gotg;
        int          expg;
        int          p;
        logic        a0, a1;
        exp_t        e;
        c = cyc;
        // responses
        if (s0_valid && s1_valid) chk("rsp_both", 1, 0);
        if (s0_valid || s1_valid) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", s1_valid ? 1 : 0, e.port);
                chk("rsp_rdata", s1_valid ? s1_rdata : s0_rdata, e.rdata);
                chk("rsp_err", s1_valid ? s1_err : s0_err, e.err);
                chk("rsp_lat", c - e.acc, 2);
                if (e.we && !e.err) shadow[e.idx] = e.wdata;
            end
        end
        // memory write strobe
        if (mem_we || c == exp_we_at) begin
            chk("mem_we", mem_we, c == exp_we_at);
            if (mem_we) begin
                chk("mem_addr", mem_addr, exp_we_addr);
                chk("mem_wdata", mem_wdata, exp_we_data);
            end
        end
        // grants
        a0 = r0_valid & q0_ready;
        a1 = r1_valid & q1_ready;
        if (a0 || a1 || ((r0_valid || r1_valid) && c - last_acc >= 3)) begin
            gotg = (a0 && a1) ? 3 : a1 ? 1 : a0 ? 0 : 2;
            if (c - last_acc < 3) expg = 2;
            else if (r0_valid && r1_valid)
`ifdef DMEM_ARB_RR_EN
                expg = b_last ? 0 : 1;
`else
                expg = 0;
`endif
            else expg = r0_valid ? 0 : 1;
            chk("grant", gotg, expg);
            if (a0 || a1) begin
                p = (a1 && !a0) ? 1 : 0;
                e.port = p;
                e.we   = p ? r1_we : r0_we;
                e.idx  = int'(p ? r1_addr[10:3] : r0_addr[10:3]);
                e.err  = p ? (r1_addr[2:0] != 0) : (r0_addr[2:0] != 0);
                e.wdata = p ? r1_wdata : r0_wdata;
                e.rdata = (!e.we && !e.err) ? shadow[e.idx] : 64'd0;
                e.acc  = c;
                sb.push_back(e);
                if (e.we && !e.err) begin
                    exp_we_at   = c + 1;
                    exp_we_addr = p ? r1_addr : r0_addr;
                    exp_we_data = e.wdata;
                end
                b_last = p[0];
                last_acc = c;
                grants.push_back(p);
                n_acc++;
            end
        end
    endtask

    task automatic mon_loop();
        forever begin
            @(negedge clk);
            if (i_arst) begin
                sb.delete();
                last_acc  = -100;
                b_last    = 1'b1;
                exp_we_at = -1;
            end else begin
                mon_step();
            end
        end
    endtask

    task automatic set0(input logic v, input logic we,
                        input logic [10:0] a, input logic [63:0] d);
        r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set1(input logic v, input logic we,
                        input logic [10:0] a, input logic [63:0] d);
        r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int n, input int lim);
        int target;
        int k;
        target = n_acc + n;
        k = 0;
        while (n_acc < target && k < lim) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_acc < target) chk("accept_timeout", 0, 1);
    endtask

    initial begin
        int base;
        for (int i = 0; i < 256; i++) shadow[i] = '0;
        i_arst = 1'b1;
        set0(0, 0, 0, 0);
        set1(0, 0, 0, 0);
        fork
            mon_loop();
        join_none

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rsp0", s0_valid, 0);
        chk("rst_rsp1", s1_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rdy1", q1_ready, 0);
        step();
        i_arst = 1'b0;
        step();

        // store then load on port 0, back to back
        set0(1, 1, 11'h010, 64'hDEAD_BEEF_0000_0001);
        wait_acc(1, 10);
        step();
        set0(1, 0, 11'h010, 64'h0);
        wait_acc(1, 10);
        step();
        set0(0, 0, 0, 0);
        repeat (4) step();

        // misaligned store on port 1
        set1(1, 1, 11'h013, 64'h5555_AAAA_5555_AAAA);
        wait_acc(1, 10);
        step();
        set1(0, 0, 0, 0);
        repeat (4) step();

        // port 1 arrives while port 0 is in ACCESS
        set0(1, 0, 11'h010, 64'h0);
        wait_acc(1, 10);
        step();
        set0(0, 0, 0, 0);
        set1(1, 0, 11'h008, 64'h0);
        wait_acc(1, 10);
        step();
        set1(0, 0, 0, 0);
        repeat (4) step();

        // reset in the middle of a store's ACCESS cycle
        set0(1, 1, 11'h020, 64'h1234_5678_9ABC_DEF0);
        wait_acc(1, 10);
        step();
        set0(0, 0, 0, 0);
        #1 i_arst = 1'b1;
        #1 chk("rst_mid_we", mem_we, 0);
        @(negedge clk);
        chk("rst_mid_rsp0", s0_valid, 0);
        step();
        i_arst = 1'b0;
        repeat (3) step();
        set0(1, 0, 11'h020, 64'h0);
        wait_acc(1, 10);
        step();
        set0(1, 0, 11'h010, 64'h0);
        wait_acc(1, 10);
        step();
        set0(0, 0, 0, 0);
        repeat (4) step();

        // both ports loading continuously from a fresh reset
        i_arst = 1'b1;
        step();
        i_arst = 1'b0;
        step();
        base = grants.size();
        set0(1, 0, 11'h000, 64'h0);
        set1(1, 0, 11'h008, 64'h0);
        wait_acc(4, 30);
        for (int i = 0; i < 4; i++) begin
            if (base + i < grants.size())
`ifdef DMEM_ARB_RR_EN
                chk($sformatf("grant_seq%0d", i), grants[base + i], i % 2);
`else
                chk($sformatf("grant_seq%0d", i), grants[base + i], 0);
`endif
        end
        step();
        set0(0, 0, 0, 0);
        wait_acc(1, 10);
        chk("late_port1", grants[grants.size() - 1], 1);
        step();
        set1(0, 0, 0, 0);
        repeat (5) step();

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, 64, data word width in bits.
REQ-002 SHALL have parameter: ADDR_WIDTH, 11, byte address width in bits; word index is addr[ADDR_WIDTH-1:3].
REQ-003 SHALL have port: i_clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port: i_arst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports, for requester n in {0,1}: i_reqn_valid  input  1  request pending.
REQ-006 SHALL have ports: i_reqn_we  input  1  1=store, 0=load.
REQ-007 SHALL have ports: i_reqn_addr  input  ADDR_WIDTH  byte address.
REQ-008 SHALL have ports: i_reqn_wdata  input  DATA_WIDTH  store data.
REQ-009 SHALL have ports: o_reqn_ready  output  1  request accepted this cycle.
REQ-010 SHALL have ports: o_rspn_valid  output  1  one-cycle completion pulse (loads and stores).
REQ-011 SHALL have ports: o_rspn_rdata  output  DATA_WIDTH  load data, 0 for stores and errors.
REQ-012 SHALL have ports: o_rspn_err  output  1  misaligned access flag, qualified by o_rspn_valid.
REQ-013 SHALL have port: o_mem_we  output  1  write enable to the single-port data memory.
REQ-014 SHALL have port: o_mem_addr  output  ADDR_WIDTH  memory byte address.
REQ-015 SHALL have port: o_mem_wdata  output  DATA_WIDTH  memory write data.
REQ-016 SHALL have port: i_mem_rdata  input  DATA_WIDTH  memory read data, combinational from o_mem_addr.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; every accepted transaction occupies exactly 3 cycles.
REQ-018 In IDLE with at least one valid, SHALL select a winner, assert its o_reqn_ready combinationally that cycle, latch port id, we, addr, wdata, and go to ACCESS.
REQ-019 SHALL assert o_reqn_ready only in IDLE, for at most one port per cycle; the loser sees ready=0 and must hold its request.
REQ-020 In ACCESS, SHALL drive o_mem_addr/o_mem_wdata from the latched values and assert o_mem_we=1 only if latched we=1 and latched addr[2:0]==0.
REQ-021 At the end of ACCESS, SHALL register i_mem_rdata (load) or 0 (store/misaligned) into the response register.
REQ-022 In RESP, SHALL pulse o_rspn_valid for exactly one cycle on the latched port only, with rdata/err stable that cycle.
REQ-023 A misaligned request (addr[2:0]!=0) SHALL be accepted, SHALL NOT write memory, and SHALL respond with err=1, rdata=0.
REQ-024 o_mem_we SHALL be 0 in IDLE and RESP; o_mem_addr/o_mem_wdata hold last latched values outside ACCESS.
REQ-025 Latency: accept in cycle N, memory write at the edge ending N+1, response valid in cycle N+2, new accept possible at N+3.
REQ-026 Simultaneous valid on both ports: arbitration per REQ-030/031; the other port is served in the next IDLE if still valid.
REQ-027 Requests arriving during ACCESS/RESP SHALL be ignored until IDLE (no ready, no side effects).

Reset
REQ-028 On i_arst SHALL immediately enter IDLE, drop any in-flight transaction without response, clear o_mem_we, all o_rsp*, latched registers to 0, and set the round-robin pointer to "last granted = port 1".
REQ-029 Reset mid-ACCESS SHALL suppress the pending store (o_mem_we=0 from reset assertion onward).

Configuration
REQ-030 With DMEM_ARB_RR_EN defined, SHALL use round-robin: on tie, grant the port not granted last; pointer updates on each accept.
REQ-031 Without DMEM_ARB_RR_EN, SHALL use fixed priority: port 0 always wins a tie; no pointer state.

Verification
REQ-032 Port 0 store addr 0x010 data 0xDEAD_BEEF_0000_0001, then load 0x010 -> o_mem_we=1 one cycle at addr 0x010; load response rdata 0xDEAD_BEEF_0000_0001, err=0, 3-cycle spacing.
REQ-033 Both ports load continuously (addr 0x000, 0x008) -> RR_EN: grants 0,1,0,1; without RR_EN: port 0 every transaction, port 1 starved.
REQ-034 Port 1 store to 0x013 -> ready=1, o_mem_we never asserted, rsp1 valid with err=1, rdata=0 two cycles after accept.
REQ-035 Assert i_arst during ACCESS of a port 0 store -> o_mem_we=0, no o_rsp0_valid, FSM in IDLE, next request accepted normally.
REQ-036 Port 1 asserts valid while port 0 transaction is in ACCESS -> o_req1_ready stays 0 until next IDLE, then asserted, response 2 cycles later.
